// File: rtl/fetch_unit.sv
// Single-entry instruction fetch unit: one outstanding memory request, one buffered
// instruction, with redirect squashing and a halt opcode that freezes fetch.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 2,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              hlt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] pc_q,      pc_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [INST_W-1:0] inst_q,    inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              squash_q,  squash_d;

  // addr_q is separate from pc_q so a squashed request keeps its address
  // stable while pc already points at the redirect target.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    squash_d  = squash_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc_q;
      end

      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_ack) begin
            addr_d   = redirect_pc;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            addr_d   = pc_q;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = addr_q;
            pc_d      = pc_q + ADDR_W'(PC_STEP);
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          state_d = REQ;
        end else if (inst_ready) begin
          if (inst_q[INST_W-1 -: 4] == HALT_OP) begin
            state_d = HALTED;
          end else begin
            addr_d  = pc_q;
            state_d = REQ;
          end
        end
      end

      HALTED: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      squash_q  <= squash_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = addr_q;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc         = pc_q;
  assign hlt        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: streaming, stalls, back-pressure, redirects,
// halt, asynchronous reset and PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic [15:0] pc;
  logic        hlt;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .pc             (pc),
    .hlt            (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content seen by the bench: opcode 1 plus the low address bits.
  function automatic logic [15:0] mem(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0000", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst !== 16'h0000 || inst_pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_inst got=%h/%h exp=0000/0000", inst, inst_pc); end
    checks++; if (pc !== 16'h0000 || hlt !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_hlt got=%h/%b exp=0000/0", pc, hlt); end
    tick();
    rst_n = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req got=%b exp=0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    logic [15:0] a;
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i * 2);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_req%0d got=%b/%h/%b exp=1/%h/0", i, imem_req, imem_addr, inst_valid, a); end
      imem_rdata = mem(a);
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== a || inst !== mem(a) || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stream_inst%0d got=%b/%h/%h/%b exp=1/%h/%h/0", i, inst_valid, inst_pc, inst, imem_req, a, mem(a)); end
      tick();
    end
  endtask

  task automatic test_ack_stall();
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1; imem_rdata = mem(16'h0000);
    tick();
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d got=%b/%h/%b exp=1/0002/0", i, imem_req, imem_addr, inst_valid); end
      tick();
    end
    imem_ack = 1'b1; imem_rdata = mem(16'h0002); inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_ackcyc_valid got=%b exp=0", inst_valid); end
    tick();
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0002 || inst !== mem(16'h0002)) begin errors++; $display("[TB] FAIL stall_deliver got=%b/%h/%h exp=1/0002/%h", inst_valid, inst_pc, inst, mem(16'h0002)); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst !== mem(16'h0002) || inst_pc !== 16'h0002 || imem_req !== 1'b0 || pc !== 16'h0004) begin errors++; $display("[TB] FAIL bp_hold%0d got=%b/%h/%h/%b/%h exp=1/%h/0002/0/0004", i, inst_valid, inst, inst_pc, imem_req, pc, mem(16'h0002)); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got=%b/%h/%b exp=1/0004/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_redirect_squash();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004 || pc !== 16'h0100) begin errors++; $display("[TB] FAIL squash_pending got=%b/%h/%h exp=1/0004/0100", imem_req, imem_addr, pc); end
    imem_ack = 1'b1; imem_rdata = mem(16'h0004);
    tick();
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("[TB] FAIL squash_discard got=%b/%b/%h exp=0/1/0100", inst_valid, imem_req, imem_addr); end
    imem_rdata = mem(16'h0100);
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0100 || inst !== mem(16'h0100)) begin errors++; $display("[TB] FAIL squash_target got=%b/%h/%h exp=1/0100/%h", inst_valid, inst_pc, inst, mem(16'h0100)); end
  endtask

  task automatic test_halt();
    logic [15:0] a;
    do_reset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'(i * 2);
      imem_rdata = (a == 16'h0006) ? 16'hF000 : mem(a);
      tick();
      tick();
    end
    checks++; if (hlt !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 16'h0008) begin errors++; $display("[TB] FAIL halt_enter got=%b/%b/%b/%h exp=1/0/0/0008", hlt, imem_req, inst_valid, pc); end
    tick(); tick();
    checks++; if (hlt !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0008) begin errors++; $display("[TB] FAIL halt_frozen got=%b/%b/%h exp=1/0/0008", hlt, imem_req, pc); end
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect_valid = 1'b0;
    checks++; if (hlt !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020 || pc !== 16'h0020) begin errors++; $display("[TB] FAIL halt_exit got=%b/%b/%h/%h exp=0/1/0020/0020", hlt, imem_req, imem_addr, pc); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst_n = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset got=%b/%b/%h exp=0/0/0000", imem_req, inst_valid, pc); end
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_ack_idle got=%b/%b exp=0/0", imem_req, inst_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_req got=%b/%h/%b exp=1/0000/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE; imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_redirect got=%b/%h/%b exp=1/fffe/0", imem_req, imem_addr, inst_valid); end
    imem_rdata = mem(16'hFFFE); inst_ready = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'hFFFE || pc !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_deliver got=%b/%h/%h exp=1/fffe/0000", inst_valid, inst_pc, pc); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_next got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    imem_ack = 1'b1; imem_rdata = mem(16'h0000);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040; inst_ready = 1'b1; imem_ack = 1'b0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || inst_valid !== 1'b0 || pc !== 16'h0040) begin errors++; $display("[TB] FAIL hold_redirect got=%b/%h/%b/%h exp=1/0040/0/0040", imem_req, imem_addr, inst_valid, pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ack_stall();
    test_backpressure();
    test_redirect_squash();
    test_halt();
    test_reset_mid();
    test_wrap();
    test_redirect_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, PC / instruction address width.
REQ-002 SHALL provide parameter INST_W, default 16, instruction width (INST_W >= 4).
REQ-003 SHALL provide parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL provide parameter PC_STEP, default 2, PC increment per fetched instruction.
REQ-005 SHALL provide parameter HALT_OP, default 4'hF, opcode in inst[INST_W-1:INST_W-4] meaning halt.
REQ-006 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  response valid; may assert in the same cycle as imem_req.
- imem_rdata  in  INST_W  response data, valid with imem_ack.
- redirect_valid  in  1  branch/jump redirect pulse.
- redirect_pc  in  ADDR_W  redirect target.
- inst_valid  out  1  buffered instruction available.
- inst  out  INST_W  buffered instruction.
- inst_pc  out  ADDR_W  address of buffered instruction.
- inst_ready  in  1  consumer accepts inst.
- pc  out  ADDR_W  address of next fetch.
- hlt  out  1  fetch halted.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, HOLD, HALTED; reset state IDLE; IDLE -> REQ unconditionally next cycle.
REQ-008 In REQ, SHALL drive imem_req=1 and imem_addr=pc, both held stable until the cycle imem_ack=1.
REQ-009 On imem_ack in REQ without squash: capture imem_rdata into inst, imem_addr into inst_pc, pc <= pc+PC_STEP (mod 2^ADDR_W, 0xFFFE -> 0x0000), go to HOLD.
REQ-010 In HOLD, SHALL drive inst_valid=1 with inst/inst_pc stable and imem_req=0; single-entry buffer, no new request.
REQ-011 Transfer occurs when inst_valid && inst_ready; if transferred opcode == HALT_OP go to HALTED, else REQ next cycle.
REQ-012 Throughput with zero-latency memory and inst_ready=1 SHALL be one instruction per 2 cycles.
REQ-013 In HALTED, SHALL hold hlt=1, imem_req=0, inst_valid=0, pc frozen.
REQ-014 redirect_valid in any non-IDLE state SHALL load pc <= redirect_pc and clear hlt/inst_valid next cycle.
REQ-015 Redirect in HOLD or HALTED: buffered instruction dropped (no transfer that cycle even if inst_ready=1), go to REQ.
REQ-016 Redirect in REQ with request pending (or same-cycle imem_ack): set squash flag; the pending request SHALL stay stable until its ack, its data SHALL be discarded, then REQ issues at redirect_pc.
REQ-017 Redirect has priority over simultaneous imem_ack and transfer; a second redirect before squash clears overwrites pc only.
REQ-018 imem_ack outside REQ SHALL be ignored.

Reset
REQ-019 rst_n low SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, hlt=0, squash=0.
REQ-020 Reset mid-request SHALL abandon the request; any later imem_ack before the first post-reset request is ignored.

Verification
REQ-021 Reset release, zero-latency ack, inst_ready=1 -> requests at 0x0000, 0x0002, 0x0004; inst_valid every 2nd cycle with matching inst_pc.
REQ-022 Ack delayed 3 cycles -> imem_req/imem_addr=0x0002 stable 3 cycles; inst_valid only the cycle after ack.
REQ-023 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0, pc unchanged.
REQ-024 Redirect to 0x0100 while request for 0x0004 pending -> 0x0004 data discarded, next request 0x0100, first delivered inst_pc=0x0100.
REQ-025 Inst 0xF000 at 0x0006 transferred -> hlt=1, no requests; redirect to 0x0020 -> hlt=0, request 0x0020.
REQ-026 rst_n low during pending request -> imem_req=0, inst_valid=0, pc=RESET_PC without clock edge; pc=0xFFFE fetch -> next request 0x0000.
